control_seq: RTL and testbench
==============================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter ALU_TIMEOUT, default 15: max AWAIT cycles before abort (range 1..255).
REQ-002 i_clk  in  1  single clock; all state updates on posedge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  level; leaves IDLE or HALT.
REQ-005 i_ir_opcode  in  8  opcode field IR[15:8], valid in DECODE.
REQ-006 i_acc_pos  in  1  ACC > 0 flag, sampled in DECODE.
REQ-007 i_alu_done  in  1  ALU result valid; meaningful only in AWAIT.
REQ-008 o_ctrl  out  16  datapath strobes; bit n = Cn.
REQ-009 o_alu_op  out  3  ALU function: ADD=0, SUB=1, MPY=2, AND=3, OR=4.
REQ-010 o_busy  out  1  high in every state except IDLE and HALT.
REQ-011 o_halted  out  1  high in HALT.
REQ-012 o_illegal  out  1  one-cycle pulse on bad opcode or ALU timeout.
REQ-013 o_instr_cnt  out  16  retired-instruction count.
REQ-014 o_state  out  4  current state code, debug only.

Function
REQ-015 Strobes SHALL be: C0 MAR<-PC, C1 MBR<-PC (held 0), C2 PC+1, C3 PC<-MBR, C4 IR<-MBR, C5 MBR<-bus, C6 ALUQ<-MBR, C7 ACC<-ALU, C8 MAR<-MBR, C9 mem write, C10 ALU start, C11 ACC<-MBR, C12 MBR<-ACC, C13/C14 held 0, C15 MBR<-IR addr.
REQ-016 o_ctrl SHALL be a function of state register, latched opcode and i_alu_done only; at most one of C1/C5/C12/C15 high per cycle.
REQ-017 Opcodes: 00 NOP, 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JGZ, 06 JMP, 07 HALT, 08 MPY, 09 AND, 0A OR; all others illegal.
REQ-018 IDLE: o_ctrl=0; i_start=1 -> FETCH1.
REQ-019 FETCH1: C0 -> FETCH2. FETCH2: C5,C2 -> FETCH3. FETCH3: C4 -> DECODE.
REQ-020 DECODE: latch i_ir_opcode, assert C15; HALT->HALT; JMP->JUMP; JGZ->JUMP if i_acc_pos else FETCH1; NOP->FETCH1; illegal->FETCH1 with o_illegal; else ->ADDR.
REQ-021 JUMP: C3 -> FETCH1. ADDR: C8 -> ST1 (STORE) else RD.
REQ-022 ST1: C12 -> ST2. ST2: C9 -> FETCH1.
REQ-023 RD: C5 -> LD (LOAD) else AQ. LD: C11 -> FETCH1.
REQ-024 AQ: C6, C10 -> AWAIT; timeout counter cleared.
REQ-025 AWAIT: C7 asserted combinationally when i_alu_done=1, then -> FETCH1; counter +1 per cycle without done; on reaching ALU_TIMEOUT -> FETCH1, o_illegal, no C7.
REQ-026 o_alu_op SHALL be driven from latched opcode in AQ/AWAIT, 0 otherwise.
REQ-027 o_instr_cnt SHALL increment (wrap 16'hFFFF->0) on every exit from a terminal execute state (JGZ not-taken, NOP, JUMP, ST2, LD, AWAIT-done, HALT entry); not on illegal or timeout.
REQ-028 HALT: o_ctrl=0; i_start=1 -> FETCH1 (resume at current PC).
REQ-029 i_start SHALL be ignored outside IDLE/HALT; i_alu_done ignored outside AWAIT.

Reset
REQ-030 Reset SHALL force IDLE, latched opcode 0, counters 0, all outputs 0 immediately, including mid-instruction.

Structure
REQ-031 Opcode, ALU-op, state encodings and strobe bit indices SHALL live in shared package cpu_pkg.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Reset, i_start=1, opcode 02 -> o_ctrl per cycle: C0; C5|C2; C4; C15; C8; C5; C11; back to FETCH1; o_instr_cnt=1.
REQ-034 Opcode 03, i_alu_done on 3rd AWAIT cycle -> C6|C10 in AQ, C7 only in that cycle, o_alu_op=0 throughout.
REQ-035 Opcode 08, i_alu_done never -> 15 AWAIT cycles, o_illegal pulse, no C7, count unchanged.
REQ-036 Opcode 05 with i_acc_pos=0 then 1 -> FETCH1 after DECODE; then JUMP with C3.
REQ-037 Opcode 07 -> o_halted=1, o_ctrl=0 until i_start; opcode FF -> o_illegal one cycle.
REQ-038 i_rst_n low during ST1 -> o_ctrl=0, o_state=IDLE same cycle, no C9 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU-op, state and strobe-index encodings for control_seq.
package cpu_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH1 = 4'd1;
    localparam logic [3:0] S_FETCH2 = 4'd2;
    localparam logic [3:0] S_FETCH3 = 4'd3;
    localparam logic [3:0] S_DECODE = 4'd4;
    localparam logic [3:0] S_JUMP   = 4'd5;
    localparam logic [3:0] S_ADDR   = 4'd6;
    localparam logic [3:0] S_ST1    = 4'd7;
    localparam logic [3:0] S_ST2    = 4'd8;
    localparam logic [3:0] S_RD     = 4'd9;
    localparam logic [3:0] S_LD     = 4'd10;
    localparam logic [3:0] S_AQ     = 4'd11;
    localparam logic [3:0] S_AWAIT  = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_STORE = 8'h01;
    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JGZ   = 8'h05;
    localparam logic [7:0] OP_JMP   = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'h07;
    localparam logic [7:0] OP_MPY   = 8'h08;
    localparam logic [7:0] OP_AND   = 8'h09;
    localparam logic [7:0] OP_OR    = 8'h0A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MPY = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4
    } alu_op_e;

    // C1, C13 and C14 are reserved and permanently low
    localparam int C_MAR_PC   = 0;
    localparam int C_PC_INC   = 2;
    localparam int C_PC_MBR   = 3;
    localparam int C_IR_MBR   = 4;
    localparam int C_MBR_BUS  = 5;
    localparam int C_ALUQ_MBR = 6;
    localparam int C_ACC_ALU  = 7;
    localparam int C_MAR_MBR  = 8;
    localparam int C_MEM_WR   = 9;
    localparam int C_ALU_GO   = 10;
    localparam int C_ACC_MBR  = 11;
    localparam int C_MBR_ACC  = 12;
    localparam int C_MBR_IR   = 15;

    function automatic alu_op_e alu_op_of(input logic [7:0] op);
        return op == OP_ADD ? ALU_ADD :
               op == OP_SUB ? ALU_SUB :
               op == OP_MPY ? ALU_MPY :
               op == OP_AND ? ALU_AND :
               op == OP_OR  ? ALU_OR  : ALU_ADD;
    endfunction

endpackage

// File: rtl/control_seq_if.sv
// control_seq_if: sequencer handshake and strobe bundle between datapath and control.
interface control_seq_if;
    logic        i_start;
    logic [7:0]  i_ir_opcode;
    logic        i_acc_pos;
    logic        i_alu_done;
    logic [15:0] o_ctrl;
    logic [2:0]  o_alu_op;
    logic        o_busy;
    logic        o_halted;
    logic        o_illegal;
    logic [15:0] o_instr_cnt;
    logic [3:0]  o_state;

    modport master (
        output i_start, i_ir_opcode, i_acc_pos, i_alu_done,
        input  o_ctrl, o_alu_op, o_busy, o_halted, o_illegal, o_instr_cnt, o_state
    );

    modport slave (
        input  i_start, i_ir_opcode, i_acc_pos, i_alu_done,
        output o_ctrl, o_alu_op, o_busy, o_halted, o_illegal, o_instr_cnt, o_state
    );
endinterface

// File: rtl/control_seq.sv
// control_seq: microcoded-style accumulator CPU sequencer; one strobe word per state.
module control_seq
    import cpu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    control_seq_if.slave bus
);

    logic [3:0]  state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ill_q, ill_d;
    logic        retire;
    logic [15:0] ctrl;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        tmo_d   = tmo_q;
        ill_d   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: state_d = bus.i_start ? S_FETCH1 : state_q;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                opc_d = bus.i_ir_opcode;
                case (bus.i_ir_opcode)
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    OP_JMP: state_d = S_JUMP;
                    OP_JGZ: begin
                        state_d = bus.i_acc_pos ? S_JUMP : S_FETCH1;
                        retire  = !bus.i_acc_pos;
                    end
                    OP_NOP: begin
                        state_d = S_FETCH1;
                        retire  = 1'b1;
                    end
                    OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR: state_d = S_ADDR;
                    default: begin
                        state_d = S_FETCH1;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_JUMP: begin
                state_d = S_FETCH1;
                retire  = 1'b1;
            end
            S_ADDR: state_d = opc_q == OP_STORE ? S_ST1 : S_RD;
            S_ST1: state_d = S_ST2;
            S_ST2: begin
                state_d = S_FETCH1;
                retire  = 1'b1;
            end
            S_RD: state_d = opc_q == OP_LOAD ? S_LD : S_AQ;
            S_LD: begin
                state_d = S_FETCH1;
                retire  = 1'b1;
            end
            S_AQ: begin
                state_d = S_AWAIT;
                tmo_d   = 8'd0;
            end
            S_AWAIT: begin
                // a done on the last allowed cycle still wins over the timeout
                if (bus.i_alu_done) begin
                    state_d = S_FETCH1;
                    retire  = 1'b1;
                end else if (tmo_q == 8'(ALU_TIMEOUT - 1)) begin
                    state_d = S_FETCH1;
                    ill_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = cnt_q + {15'd0, retire};
    end

    always_comb begin
        ctrl             = '0;
        ctrl[C_MAR_PC]   = state_q == S_FETCH1;
        ctrl[C_PC_INC]   = state_q == S_FETCH2;
        ctrl[C_MBR_BUS]  = state_q == S_FETCH2 || state_q == S_RD;
        ctrl[C_IR_MBR]   = state_q == S_FETCH3;
        ctrl[C_MBR_IR]   = state_q == S_DECODE;
        ctrl[C_PC_MBR]   = state_q == S_JUMP;
        ctrl[C_MAR_MBR]  = state_q == S_ADDR;
        ctrl[C_MBR_ACC]  = state_q == S_ST1;
        ctrl[C_MEM_WR]   = state_q == S_ST2;
        ctrl[C_ACC_MBR]  = state_q == S_LD;
        ctrl[C_ALUQ_MBR] = state_q == S_AQ;
        ctrl[C_ALU_GO]   = state_q == S_AQ;
        ctrl[C_ACC_ALU]  = state_q == S_AWAIT && bus.i_alu_done;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            opc_q   <= 8'd0;
            tmo_q   <= 8'd0;
            cnt_q   <= 16'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.o_ctrl      = ctrl;
    assign bus.o_alu_op    = (state_q == S_AQ || state_q == S_AWAIT) ? alu_op_of(opc_q) : ALU_ADD;
    assign bus.o_busy      = state_q != S_IDLE && state_q != S_HALT;
    assign bus.o_halted    = state_q == S_HALT;
    assign bus.o_illegal   = ill_q;
    assign bus.o_instr_cnt = cnt_q;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: instruction-level reference model plus literal directed checks for control_seq.
module tb_control_seq;
    import cpu_pkg::*;

    localparam int TMO = 15;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    typedef struct {
        logic        start;
        logic [7:0]  op;
        logic        acc;
        logic        done;
        logic [15:0] ctrl;
        logic [2:0]  alu;
        logic        busy;
        logic        halted;
        logic        retire;
        logic        ill;
    } cyc_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    control_seq_if bus();

    control_seq #(.ALU_TIMEOUT(TMO)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int mode = M_IDLE;
    cyc_t plan[$];
    cyc_t expq[$];
    int m_cnt = 0;
    logic m_ill = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] b(input int n);
        return 16'(1) << n;
    endfunction

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        case (op)
            8'h04: return 3'd1;
            8'h08: return 3'd2;
            8'h09: return 3'd3;
            8'h0A: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic cyc_t mk(input logic [15:0] ctrl);
        cyc_t c;
        c.start  = 1'($urandom);
        c.op     = 8'($urandom);
        c.acc    = 1'($urandom);
        c.done   = 1'($urandom);
        c.ctrl   = ctrl;
        c.alu    = 3'd0;
        c.busy   = 1'b1;
        c.halted = 1'b0;
        c.retire = 1'b0;
        c.ill    = 1'b0;
        return c;
    endfunction

    // expand one instruction into its expected cycle-by-cycle trace
    task automatic instr(input logic [7:0] op, input logic acc, input int done_at);
        cyc_t c;
        logic [2:0] code;
        code = alu_code(op);
        if (mode != M_RUN) begin
            repeat ($urandom_range(0, 2)) begin
                c = mk(16'h0); c.start = 1'b0; c.busy = 1'b0; c.halted = mode == M_HALT;
                plan.push_back(c);
            end
            c = mk(16'h0); c.start = 1'b1; c.busy = 1'b0; c.halted = mode == M_HALT;
            plan.push_back(c);
            mode = M_RUN;
        end
        plan.push_back(mk(b(0)));
        plan.push_back(mk(b(5) | b(2)));
        plan.push_back(mk(b(4)));
        c = mk(b(15)); c.op = op; c.acc = acc;
        if (op > 8'h0A) begin
            c.ill = 1'b1;
            plan.push_back(c);
            return;
        end
        case (op)
            8'h00: begin c.retire = 1'b1; plan.push_back(c); end
            8'h07: begin c.retire = 1'b1; plan.push_back(c); mode = M_HALT; end
            8'h05, 8'h06: begin
                if (op == 8'h05 && !acc) begin
                    c.retire = 1'b1; plan.push_back(c);
                end else begin
                    plan.push_back(c);
                    c = mk(b(3)); c.retire = 1'b1; plan.push_back(c);
                end
            end
            8'h01: begin
                plan.push_back(c);
                plan.push_back(mk(b(8)));
                plan.push_back(mk(b(12)));
                c = mk(b(9)); c.retire = 1'b1; plan.push_back(c);
            end
            8'h02: begin
                plan.push_back(c);
                plan.push_back(mk(b(8)));
                plan.push_back(mk(b(5)));
                c = mk(b(11)); c.retire = 1'b1; plan.push_back(c);
            end
            default: begin
                plan.push_back(c);
                plan.push_back(mk(b(8)));
                plan.push_back(mk(b(5)));
                c = mk(b(6) | b(10)); c.alu = code; plan.push_back(c);
                for (int i = 0; i < TMO; i++) begin
                    c = mk(16'h0); c.alu = code; c.done = i == done_at;
                    if (c.done) begin
                        c.ctrl = b(7); c.retire = 1'b1; plan.push_back(c);
                        break;
                    end
                    c.ill = i == TMO - 1;
                    plan.push_back(c);
                end
            end
        endcase
    endtask

    task automatic cyc(input logic s, input logic [7:0] op, input logic a, input logic d);
        @(posedge i_clk);
        #1;
        bus.i_start = s;
        bus.i_ir_opcode = op;
        bus.i_acc_pos = a;
        bus.i_alu_done = d;
        @(negedge i_clk);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            m_cnt = 0;
            m_ill = 1'b0;
        end else if (expq.size() > 0) begin
            cyc_t e;
            e = expq.pop_front();
            chk("m_ctrl", bus.o_ctrl, e.ctrl);
            chk("m_alu_op", 16'(bus.o_alu_op), 16'(e.alu));
            chk("m_busy", 16'(bus.o_busy), 16'(e.busy));
            chk("m_halted", 16'(bus.o_halted), 16'(e.halted));
            chk("m_illegal", 16'(bus.o_illegal), 16'(m_ill));
            chk("m_instr_cnt", bus.o_instr_cnt, 16'(m_cnt));
            m_cnt = (m_cnt + int'(e.retire)) % 65536;
            m_ill = e.ill;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    logic [15:0] load_exp [9] = '{16'h0000, 16'h0001, 16'h0024, 16'h0010, 16'h8000,
                                  16'h0100, 16'h0020, 16'h0800, 16'h0001};
    logic [7:0] op_tab [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h7F, 8'hFF};

    initial begin
        bus.i_start = 1'b0;
        bus.i_ir_opcode = 8'h00;
        bus.i_acc_pos = 1'b0;
        bus.i_alu_done = 1'b0;
        #2 i_rst_n = 1'b0;
        #2;
        chk("rst_ctrl", bus.o_ctrl, 16'h0000);
        chk("rst_state", 16'(bus.o_state), 16'(S_IDLE));
        chk("rst_busy", 16'(bus.o_busy), 16'h0);
        chk("rst_halted", 16'(bus.o_halted), 16'h0);
        chk("rst_illegal", 16'(bus.o_illegal), 16'h0);
        chk("rst_cnt", bus.o_instr_cnt, 16'h0000);
        chk("rst_alu_op", 16'(bus.o_alu_op), 16'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(i == 0, 8'h02, 1'b0, 1'b0);
            chk("load_seq", bus.o_ctrl, load_exp[i]);
        end
        chk("load_cnt", bus.o_instr_cnt, 16'h0001);
        cyc(1'b0, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF, 1'b0, 1'b0);
        cyc(1'b0, 8'hFF, 1'b0, 1'b0);
        chk("bad_decode", bus.o_ctrl, 16'h8000);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bad_pulse", 16'(bus.o_illegal), 16'h1);
        chk("bad_fetch", bus.o_ctrl, 16'h0001);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bad_once", 16'(bus.o_illegal), 16'h0);
        chk("bad_cnt", bus.o_instr_cnt, 16'h0001);
        cyc(1'b0, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 8'h01, 1'b0, 1'b0);
        chk("st_addr", bus.o_ctrl, 16'h0100);
        cyc(1'b0, 8'h01, 1'b0, 1'b0);
        chk("st1_ctrl", bus.o_ctrl, 16'h1000);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", bus.o_ctrl, 16'h0000);
        chk("midrst_state", 16'(bus.o_state), 16'(S_IDLE));
        chk("midrst_busy", 16'(bus.o_busy), 16'h0);
        chk("midrst_cnt", bus.o_instr_cnt, 16'h0000);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) begin
            cyc(1'b0, 8'h01, 1'b0, 1'b0);
            chk("no_c9", bus.o_ctrl, 16'h0000);
        end
        mode = M_IDLE;
        instr(8'h03, 1'b0, 2);
        instr(8'h08, 1'b0, 1000);
        instr(8'h05, 1'b0, 0);
        instr(8'h05, 1'b1, 0);
        instr(8'h07, 1'b0, 0);
        instr(8'hFF, 1'b0, 0);
        instr(8'h01, 1'b0, 0);
        instr(8'h06, 1'b0, 0);
        instr(8'h00, 1'b0, 0);
        instr(8'h04, 1'b0, 0);
        instr(8'h09, 1'b1, TMO - 1);
        instr(8'h0A, 1'b0, 5);
        repeat (40) instr(op_tab[$urandom_range(0, 13)], 1'($urandom), $urandom_range(0, TMO + 3));
        while (plan.size() > 0) begin
            cyc_t c;
            c = plan.pop_front();
            @(posedge i_clk);
            #1;
            bus.i_start = c.start;
            bus.i_ir_opcode = c.op;
            bus.i_acc_pos = c.acc;
            bus.i_alu_done = c.done;
            expq.push_back(c);
        end
        repeat (2) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
